// File: rtl/booth_mul8_pkg.sv
// Shared constants for the Booth multiplier controller: FSM encoding and iteration count.
package booth_mul8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ITER  = 8;
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

endpackage

// File: rtl/booth_mul8_ripple8.sv
// 8-bit ripple add/sub unit: out = a + b (s=0) or a - b (s=1), with carry-out and signed overflow.
module booth_mul8_ripple8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       s,
    output logic [7:0] out,
    output logic       c,
    output logic       v
);

    logic [7:0] bx;
    logic [8:0] cy;

    assign bx = b ^ {8{s}};

    always_comb begin
        cy    = '0;
        out   = '0;
        cy[0] = s;
        for (int i = 0; i < 8; i++) begin
            out[i]  = a[i] ^ bx[i] ^ cy[i];
            cy[i+1] = (a[i] & bx[i]) | (cy[i] & (a[i] ^ bx[i]));
        end
    end

    assign c = cy[8];
    assign v = cy[8] ^ cy[7];

endmodule

// File: rtl/booth_mul8_ctrl.sv
// Multi-cycle signed 8x8 radix-2 Booth multiplier sharing one 8-bit add/sub unit.
// Result after 8 iterations; done pulses for one cycle, product/ovf8 held until next completion.
module booth_mul8_ctrl
    import booth_mul8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        ovf8
);

    state_t state, state_nxt;

    logic [7:0]       acc;
    logic [7:0]       q;
    logic [7:0]       m;
    logic             q_1;
    logic [CNT_W-1:0] cnt;

    logic [1:0]  pair;
    logic        add_en;
    logic        sub;
    logic [7:0]  sum;
    logic        add_c_unused;
    logic        add_v;
    logic [7:0]  acc_sum;
    logic        sign;
    logic [7:0]  acc_sh;
    logic [7:0]  q_sh;
    logic [15:0] final_p;

    assign pair   = {q[0], q_1};
    assign add_en = (pair == 2'b01) || (pair == 2'b10);
    assign sub    = (pair == 2'b10);

    booth_mul8_ripple8 u_addsub (
        .a   (acc),
        .b   (m),
        .s   (sub),
        .out (sum),
        .c   (add_c_unused),
        .v   (add_v)
    );

    // Overflow-corrected sign keeps M = -128 exact without a 9th accumulator bit.
    assign acc_sum = add_en ? sum : acc;
    assign sign    = add_en ? (sum[7] ^ add_v) : acc[7];
    assign acc_sh  = {sign, acc_sum[7:1]};
    assign q_sh    = {acc_sum[0], q[7:1]};
    assign final_p = {acc_sh, q_sh};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_CALC;
            ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            q       <= '0;
            m       <= '0;
            q_1     <= 1'b0;
            cnt     <= '0;
            product <= '0;
            ovf8    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_nxt == ST_CALC);
            done <= (state_nxt == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m   <= a;
                        q   <= b;
                        acc <= '0;
                        q_1 <= 1'b0;
                        cnt <= '0;
                    end
                end
                ST_CALC: begin
                    acc <= acc_sh;
                    q   <= q_sh;
                    q_1 <= q[0];
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        product <= final_p;
                        ovf8    <= ~((&final_p[15:7]) | ~(|final_p[15:7]));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul8_ctrl.sv
// Directed and random checks of booth_mul8_ctrl against plain integer multiplication.
module tb_booth_mul8_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        ovf8;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int done_cyc;
    int prev_done_cyc;
    logic [15:0] last_prod;
    logic        last_ovf;

    booth_mul8_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .ovf8    (ovf8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. With scramble set, start/a/b are
    // randomised while the operation runs and start is left high afterwards.
    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input bit scramble);
        int          p;
        logic [15:0] ep;
        logic        eo;
        p  = int'($signed(ai)) * int'($signed(bi));
        ep = p[15:0];
        eo = (p < -128) || (p > 127);
        a = ai;
        b = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!scramble) start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_calc", 32'(busy), 32'd1);
            chk("done_calc", 32'(done), 32'd0);
            if (i == 0) begin
                chk("prod_hold", 32'(product), 32'(last_prod));
                chk("ovf_hold", 32'(ovf8), 32'(last_ovf));
            end
            if (scramble) begin
                a = 8'($urandom);
                b = 8'($urandom);
                start = 1'($urandom);
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("product", 32'(product), 32'(ep));
        chk("ovf8", 32'(ovf8), 32'(eo));
        prev_done_cyc = done_cyc;
        done_cyc = cyc;
        last_prod = ep;
        last_ovf = eo;
        if (scramble) start = 1'($urandom);
        @(negedge clk);
        chk("done_off", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("prod_keep", 32'(product), 32'(ep));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        done_cyc = 0;
        prev_done_cyc = 0;
        last_prod = '0;
        last_ovf = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prod", 32'(product), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(8'd3, 8'd5, 1'b0);
        chk("t1_val", 32'(product), 32'h000F);
        run_op(8'h80, 8'h80, 1'b0);
        chk("t2_neg128sq", 32'(product), 32'h4000);
        chk("t2_ovf", 32'(ovf8), 32'd1);
        run_op(8'h80, 8'h01, 1'b0);
        chk("t2_neg128x1", 32'(product), 32'hFF80);
        run_op(8'hFF, 8'd127, 1'b0);
        chk("t3_m1x127", 32'(product), 32'hFF81);
        run_op(8'h00, 8'hA5, 1'b0);
        run_op(8'd127, 8'd127, 1'b0);
        chk("t3_127sq", 32'(product), 32'h3F01);

        // Held start with inputs scrambled during CALC: one result every 10 cycles
        for (int k = 0; k < 6; k++) begin
            run_op(8'($urandom), 8'($urandom), 1'b1);
            if (k > 0) chk("b2b_period", 32'(done_cyc - prev_done_cyc), 32'd10);
        end
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_b2b", 32'(busy), 32'd0);

        // Asynchronous reset mid-CALC, after the previous result left ovf8 set
        run_op(8'd127, 8'd127, 1'b0);
        a = 8'd55;
        b = 8'd66;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_prod", 32'(product), 32'd0);
        chk("arst_ovf", 32'(ovf8), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            chk("arst_no_done", 32'(done), 32'd0);
        end
        last_prod = '0;
        last_ovf = 1'b0;
        run_op(8'hF9, 8'd9, 1'b0);
        chk("t5_m7x9", 32'(product), 32'hFFC1);

        // Random signed operands
        for (int k = 0; k < 1000; k++) begin
            run_op(8'($urandom), 8'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
